// File: rtl/alu_op_ctrl.sv
// alu_op_ctrl: sequences one ARM data-processing request through the shared
// 32-bit ALU, owns the NZCV flag register and presents the result.
// Optional build macro ALU_MUL_EN adds an iterative shift-add multiply that
// reuses the ALU for 32 cycles; without it REQ_MUL is ignored.
module alu_op_ctrl #(
  parameter int unsigned DW = 32
) (
  input  logic          CLK,
  input  logic          nRESET,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic [3:0]    REQ_OPCODE,
  input  logic          REQ_S,
  input  logic          REQ_MUL,
  input  logic [DW-1:0] REQ_A,
  input  logic [DW-1:0] REQ_B,
  input  logic          REQ_SHC,
  output logic [DW-1:0] ALU_A,
  output logic [DW-1:0] ALU_B,
  output logic          ALU_INVA,
  output logic          ALU_INVB,
  output logic          ALU_PASSA,
  output logic          ALU_PASSB,
  output logic          ALU_AND,
  output logic          ALU_ORR,
  output logic          ALU_EOR,
  output logic          ALU_CIN,
  output logic          ALU_CUSE,
  input  logic [DW-1:0] ALU_DOUT,
  input  logic          ALU_C,
  input  logic          ALU_V,
  input  logic          ALU_N,
  input  logic          ALU_Z,
  output logic          RES_VALID,
  input  logic          RES_READY,
  output logic [DW-1:0] RES_DATA,
  output logic          RES_WE,
  output logic [3:0]    FLAGS
);

  localparam int unsigned CTRL_W  = 9;
  localparam int unsigned B_INVA  = 8;
  localparam int unsigned B_INVB  = 7;
  localparam int unsigned B_PASSA = 6;
  localparam int unsigned B_PASSB = 5;
  localparam int unsigned B_AND   = 4;
  localparam int unsigned B_ORR   = 3;
  localparam int unsigned B_EOR   = 2;
  localparam int unsigned B_CIN   = 1;
  localparam int unsigned B_CUSE  = 0;

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [DW-1:0]       alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]          op_q, op_d;
  logic                s_q, s_d, shc_q, shc_d;
  logic [DW-1:0]       res_data_q, res_data_d;
  logic                res_we_q, res_we_d, res_valid_q, res_valid_d;
  logic                req_ready_q, req_ready_d;
  logic [3:0]          flags_q, flags_d;

`ifdef ALU_MUL_EN
  logic [DW-1:0]       mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [4:0]          mul_i_q, mul_i_d;
`else
  logic                unused_mul;
  assign unused_mul = REQ_MUL;
`endif

  // ALU control decode for a data-processing opcode; c is the latched carry
  function automatic logic [CTRL_W-1:0] decode(input logic [3:0] op, input logic c);
    logic [CTRL_W-1:0] k;
    k = '0;
    case (op)
      4'h0, 4'h8: k[B_AND] = 1'b1;
      4'h1, 4'h9: k[B_EOR] = 1'b1;
      4'hC:       k[B_ORR] = 1'b1;
      4'hE:       begin k[B_AND] = 1'b1; k[B_INVB] = 1'b1; end
      4'hD:       k[B_PASSB] = 1'b1;
      4'hF:       begin k[B_PASSB] = 1'b1; k[B_INVB] = 1'b1; end
      4'h2, 4'hA: begin k[B_INVB] = 1'b1; k[B_CIN] = 1'b1; k[B_CUSE] = 1'b1; end
      4'h3:       begin k[B_INVA] = 1'b1; k[B_CIN] = 1'b1; k[B_CUSE] = 1'b1; end
      4'h5:       begin k[B_CIN] = c; k[B_CUSE] = 1'b1; end
      4'h6:       begin k[B_INVB] = 1'b1; k[B_CIN] = c; k[B_CUSE] = 1'b1; end
      4'h7:       begin k[B_INVA] = 1'b1; k[B_CIN] = c; k[B_CUSE] = 1'b1; end
      default:    k = '0;
    endcase
    return k;
  endfunction

  function automatic logic is_arith(input logic [3:0] op);
    return ((op >= 4'h2) && (op <= 4'h7)) || (op == 4'hA) || (op == 4'hB);
  endfunction

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      state_q     <= IDLE;
      ctrl_q      <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      op_q        <= '0;
      s_q         <= 1'b0;
      shc_q       <= 1'b0;
      res_data_q  <= '0;
      res_we_q    <= 1'b0;
      res_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      flags_q     <= '0;
`ifdef ALU_MUL_EN
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_i_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      op_q        <= op_d;
      s_q         <= s_d;
      shc_q       <= shc_d;
      res_data_q  <= res_data_d;
      res_we_q    <= res_we_d;
      res_valid_q <= res_valid_d;
      req_ready_q <= req_ready_d;
      flags_q     <= flags_d;
`ifdef ALU_MUL_EN
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_i_q     <= mul_i_d;
`endif
    end
  end

  // Next-state logic; ALU controls and operands are registered so they are
  // valid exactly while in EXEC/MUL and zero otherwise
  always_comb begin
    state_d     = state_q;
    ctrl_d      = '0;
    alu_a_d     = '0;
    alu_b_d     = '0;
    op_d        = op_q;
    s_d         = s_q;
    shc_d       = shc_q;
    res_data_d  = res_data_q;
    res_we_d    = res_we_q;
    res_valid_d = res_valid_q;
    req_ready_d = req_ready_q;
    flags_d     = flags_q;
`ifdef ALU_MUL_EN
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_i_d     = mul_i_q;
`endif
    case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          op_d        = REQ_OPCODE;
          s_d         = REQ_S;
          shc_d       = REQ_SHC;
          req_ready_d = 1'b0;
`ifdef ALU_MUL_EN
          if (REQ_MUL) begin
            state_d         = MUL;
            mul_a_d         = REQ_A;
            mul_b_d         = REQ_B;
            mul_i_d         = '0;
            alu_b_d         = REQ_A;
            ctrl_d[B_PASSA] = ~REQ_B[0];
          end else begin
            state_d = EXEC;
            ctrl_d  = decode(REQ_OPCODE, flags_q[1]);
            alu_a_d = REQ_A;
            alu_b_d = REQ_B;
          end
`else
          state_d = EXEC;
          ctrl_d  = decode(REQ_OPCODE, flags_q[1]);
          alu_a_d = REQ_A;
          alu_b_d = REQ_B;
`endif
        end
      end
      EXEC: begin
        res_data_d  = ALU_DOUT;
        res_we_d    = (op_q[3:2] != 2'b10);
        res_valid_d = 1'b1;
        state_d     = DONE;
        if (s_q) begin
          flags_d[3] = ALU_N;
          flags_d[2] = ALU_Z;
          if (is_arith(op_q)) begin
            flags_d[1] = ALU_C;
            flags_d[0] = ALU_V;
          end else begin
            flags_d[1] = shc_q;
          end
        end
      end
      MUL: begin
`ifdef ALU_MUL_EN
        if (mul_i_q == 5'd31) begin
          res_data_d  = ALU_DOUT;
          res_we_d    = 1'b1;
          res_valid_d = 1'b1;
          state_d     = DONE;
          if (s_q) begin
            flags_d[3] = ALU_N;
            flags_d[2] = ALU_Z;
          end
        end else begin
          mul_i_d         = mul_i_q + 5'd1;
          alu_a_d         = ALU_DOUT;
          alu_b_d         = mul_a_q << (mul_i_q + 5'd1);
          ctrl_d[B_PASSA] = ~mul_b_q[mul_i_q + 5'd1];
        end
`else
        state_d     = IDLE;
        req_ready_d = 1'b1;
`endif
      end
      DONE: begin
        if (RES_READY) begin
          res_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        res_valid_d = 1'b0;
      end
    endcase
  end

  assign REQ_READY = req_ready_q;
  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_INVA  = ctrl_q[B_INVA];
  assign ALU_INVB  = ctrl_q[B_INVB];
  assign ALU_PASSA = ctrl_q[B_PASSA];
  assign ALU_PASSB = ctrl_q[B_PASSB];
  assign ALU_AND   = ctrl_q[B_AND];
  assign ALU_ORR   = ctrl_q[B_ORR];
  assign ALU_EOR   = ctrl_q[B_EOR];
  assign ALU_CIN   = ctrl_q[B_CIN];
  assign ALU_CUSE  = ctrl_q[B_CUSE];
  assign RES_VALID = res_valid_q;
  assign RES_DATA  = res_data_q;
  assign RES_WE    = res_we_q;
  assign FLAGS     = flags_q;

endmodule

// File: tb/tb_alu_op_ctrl.sv
// Testbench for alu_op_ctrl: behavioural ALU attached to the control lines,
// directed data-processing vectors, backpressure, mid-operation reset and,
// when ALU_MUL_EN is defined, the iterative multiply.
module tb_alu_op_ctrl;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic        REQ_VALID, REQ_READY;
  logic [3:0]  REQ_OPCODE;
  logic        REQ_S, REQ_MUL, REQ_SHC;
  logic [31:0] REQ_A, REQ_B;
  logic [31:0] ALU_A, ALU_B, ALU_DOUT;
  logic        ALU_INVA, ALU_INVB, ALU_PASSA, ALU_PASSB, ALU_AND, ALU_ORR, ALU_EOR;
  logic        ALU_CIN, ALU_CUSE, ALU_C, ALU_V, ALU_N, ALU_Z;
  logic        RES_VALID, RES_READY, RES_WE;
  logic [31:0] RES_DATA;
  logic [3:0]  FLAGS;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  alu_op_ctrl #(.DW(32)) dut (
    .CLK(CLK), .nRESET(nRESET),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OPCODE(REQ_OPCODE),
    .REQ_S(REQ_S), .REQ_MUL(REQ_MUL), .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_SHC(REQ_SHC),
    .ALU_A(ALU_A), .ALU_B(ALU_B),
    .ALU_INVA(ALU_INVA), .ALU_INVB(ALU_INVB), .ALU_PASSA(ALU_PASSA), .ALU_PASSB(ALU_PASSB),
    .ALU_AND(ALU_AND), .ALU_ORR(ALU_ORR), .ALU_EOR(ALU_EOR),
    .ALU_CIN(ALU_CIN), .ALU_CUSE(ALU_CUSE),
    .ALU_DOUT(ALU_DOUT), .ALU_C(ALU_C), .ALU_V(ALU_V), .ALU_N(ALU_N), .ALU_Z(ALU_Z),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
    .RES_WE(RES_WE), .FLAGS(FLAGS)
  );

  // Behavioural shared ALU driven by the controller's control lines
  logic [31:0] am, bm;
  logic [32:0] sum;
  always_comb begin
    am  = ALU_INVA ? ~ALU_A : ALU_A;
    bm  = ALU_INVB ? ~ALU_B : ALU_B;
    sum = {1'b0, am} + {1'b0, bm} + 33'(ALU_CUSE & ALU_CIN);
    if (ALU_PASSA)      ALU_DOUT = am;
    else if (ALU_PASSB) ALU_DOUT = bm;
    else if (ALU_AND)   ALU_DOUT = am & bm;
    else if (ALU_ORR)   ALU_DOUT = am | bm;
    else if (ALU_EOR)   ALU_DOUT = am ^ bm;
    else                ALU_DOUT = sum[31:0];
    ALU_C = sum[32];
    ALU_V = (am[31] == bm[31]) && (sum[31] != am[31]);
    ALU_N = ALU_DOUT[31];
    ALU_Z = (ALU_DOUT == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Present a request and wait (bounded) until it is accepted at a posedge
  task automatic issue(input logic [3:0] op, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic shc, input logic mul);
    bit ok;
    ok = 1'b0;
    REQ_VALID = 1'b1; REQ_OPCODE = op; REQ_S = s; REQ_A = a; REQ_B = b;
    REQ_SHC = shc; REQ_MUL = mul;
    for (int n = 0; n < 10 && !ok; n++) begin
      ok = REQ_READY;
      @(posedge CLK); #1;
    end
    REQ_VALID = 1'b0;
    check("accept", 32'(ok), 32'd1);
  endtask

  task automatic pop();
    RES_READY = 1'b1;
    @(posedge CLK); #1;
    RES_READY = 1'b0;
    check("pop_valid", 32'(RES_VALID), 32'd0);
    check("pop_ready", 32'(REQ_READY), 32'd1);
  endtask

  // One data-processing operation: controls during EXEC, result one edge later
  task automatic run_dp(input string tag, input logic [3:0] op, input logic s,
                        input logic [31:0] a, input logic [31:0] b, input logic shc,
                        input logic [8:0] exp_ctrl, input logic [31:0] exp_data,
                        input logic exp_we, input logic [3:0] exp_flags, input int hold);
    issue(op, s, a, b, shc, 1'b0);
    check({tag, "_busy"}, 32'(RES_VALID), 32'd0);
    check({tag, "_ctrl"}, 32'({ALU_INVA, ALU_INVB, ALU_PASSA, ALU_PASSB, ALU_AND,
                               ALU_ORR, ALU_EOR, ALU_CIN, ALU_CUSE}), 32'(exp_ctrl));
    @(posedge CLK); #1;
    check({tag, "_valid"}, 32'(RES_VALID), 32'd1);
    check({tag, "_data"}, RES_DATA, exp_data);
    check({tag, "_we"}, 32'(RES_WE), 32'(exp_we));
    check({tag, "_flags"}, 32'(FLAGS), 32'(exp_flags));
    for (int h = 0; h < hold; h++) begin
      @(posedge CLK); #1;
      check({tag, "_hold_valid"}, 32'(RES_VALID), 32'd1);
      check({tag, "_hold_data"}, RES_DATA, exp_data);
      check({tag, "_hold_ready"}, 32'(REQ_READY), 32'd0);
      check({tag, "_hold_alu"}, {ALU_A[15:0], ALU_B[15:0]}, 32'd0);
    end
    pop();
  endtask

  initial begin
    nRESET = 1'b0; REQ_VALID = 1'b0; REQ_OPCODE = 4'h0; REQ_S = 1'b0; REQ_MUL = 1'b0;
    REQ_A = 32'd0; REQ_B = 32'd0; REQ_SHC = 1'b0; RES_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_flags", 32'(FLAGS), 32'd0);
    check("rst_valid", 32'(RES_VALID), 32'd0);
    check("rst_ready", 32'(REQ_READY), 32'd1);
    check("rst_alu_a", ALU_A, 32'd0);
    check("rst_ctrl", 32'({ALU_INVA, ALU_INVB, ALU_PASSA, ALU_PASSB, ALU_AND,
                          ALU_ORR, ALU_EOR, ALU_CIN, ALU_CUSE}), 32'd0);
    nRESET = 1'b1;

    //      tag    op    S     A             B             SHC   ctrl          data          WE    NZCV     hold
    run_dp("add", 4'h4, 1'b1, 32'h7FFFFFFF, 32'h1,        1'b0, 9'b000000000, 32'h80000000, 1'b1, 4'b1001, 0);
    run_dp("mov", 4'hD, 1'b1, 32'h0,        32'h5,        1'b0, 9'b000100000, 32'h5,        1'b1, 4'b0001, 0);
    run_dp("cmp", 4'hA, 1'b1, 32'h5,        32'h5,        1'b0, 9'b010000011, 32'h0,        1'b0, 4'b0110, 0);
    run_dp("adc", 4'h5, 1'b0, 32'h1,        32'h1,        1'b0, 9'b000000011, 32'h3,        1'b1, 4'b0110, 0);
    run_dp("bic", 4'hE, 1'b1, 32'hFF,       32'h0F,       1'b1, 9'b010010000, 32'hF0,       1'b1, 4'b0010, 4);
    run_dp("sub", 4'h2, 1'b1, 32'h3,        32'h5,        1'b0, 9'b010000011, 32'hFFFFFFFE, 1'b1, 4'b1000, 0);
    run_dp("sbc", 4'h6, 1'b1, 32'd10,       32'd3,        1'b0, 9'b010000001, 32'd6,        1'b1, 4'b0010, 0);
    run_dp("rsc", 4'h7, 1'b1, 32'd3,        32'd10,       1'b0, 9'b100000011, 32'd7,        1'b1, 4'b0010, 0);
    run_dp("teq", 4'h9, 1'b1, 32'hF0F0,     32'hF0F0,     1'b0, 9'b000000100, 32'h0,        1'b0, 4'b0100, 0);
    run_dp("mvn", 4'hF, 1'b1, 32'h0,        32'h0,        1'b0, 9'b010100000, 32'hFFFFFFFF, 1'b1, 4'b1000, 0);
    run_dp("orr", 4'hC, 1'b0, 32'h1,        32'h2,        1'b0, 9'b000001000, 32'h3,        1'b1, 4'b1000, 0);
    run_dp("cmn", 4'hB, 1'b1, 32'hFFFFFFFF, 32'h1,        1'b0, 9'b000000000, 32'h0,        1'b0, 4'b0110, 0);
    run_dp("rsb", 4'h3, 1'b1, 32'h1,        32'd10,       1'b0, 9'b100000011, 32'd9,        1'b1, 4'b0010, 0);
    run_dp("and", 4'h0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 9'b000010000, 32'h80000000, 1'b1, 4'b1000, 0);
    run_dp("tst", 4'h8, 1'b1, 32'h1,        32'h2,        1'b1, 9'b000010000, 32'h0,        1'b0, 4'b0110, 0);
    run_dp("eor", 4'h1, 1'b1, 32'h1,        32'h3,        1'b0, 9'b000000100, 32'h2,        1'b1, 4'b0000, 0);

`ifndef ALU_MUL_EN
    // Without the multiply option REQ_MUL must not change the path
    issue(4'h4, 1'b0, 32'd2, 32'd3, 1'b0, 1'b1);
    @(posedge CLK); #1;
    check("nomul_valid", 32'(RES_VALID), 32'd1);
    check("nomul_data", RES_DATA, 32'd5);
    pop();
`endif

    // Reset while a result is pending
    issue(4'h4, 1'b1, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0);
    @(posedge CLK); #1;
    check("mid_valid", 32'(RES_VALID), 32'd1);
    check("mid_flags", 32'(FLAGS), 32'h9);
    nRESET = 1'b0;
    @(posedge CLK); #1;
    nRESET = 1'b1;
    check("mid_rst_valid", 32'(RES_VALID), 32'd0);
    check("mid_rst_flags", 32'(FLAGS), 32'd0);
    check("mid_rst_ready", 32'(REQ_READY), 32'd1);
    check("mid_rst_data", RES_DATA, 32'd0);

`ifdef ALU_MUL_EN
    begin
      int cnt;
      issue(4'h0, 1'b1, 32'd1234, 32'd5678, 1'b0, 1'b1);
      cnt = 1;
      @(posedge CLK); #1;
      while (!RES_VALID && cnt < 100) begin
        @(posedge CLK); #1;
        cnt++;
      end
      check("mul_latency", 32'(cnt), 32'd32);
      check("mul_data", RES_DATA, 32'd7006652);
      check("mul_we", 32'(RES_WE), 32'd1);
      check("mul_nz", 32'(FLAGS[3:2]), 32'd0);
      pop();
      issue(4'h0, 1'b1, 32'd1234, 32'd0, 1'b0, 1'b1);
      cnt = 1;
      @(posedge CLK); #1;
      while (!RES_VALID && cnt < 100) begin
        @(posedge CLK); #1;
        cnt++;
      end
      check("mul0_latency", 32'(cnt), 32'd32);
      check("mul0_data", RES_DATA, 32'd0);
      check("mul0_nz", 32'(FLAGS[3:2]), 32'd1);
      pop();
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_op_ctrl.md
Name: alu_op_ctrl

Overview:
- Sequencer and flag owner for the shared 32-bit ALU datapath.
- Accepts one ARM data-processing request at a time over a valid/ready handshake, then drives the ALU control lines (INVA/INVB/PASSA/PASSB/AND/ORR/EOR/CFLAGIN/CFLAGUSE).
- Captures the ALU result, updates the NZCV register, and presents the result over a second valid/ready handshake.
- Sits between the decode stage and the ALU instance.

Parameters:
- DW, 32, datapath width (only 32 is supported).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- nRESET  in  1  synchronous active-low reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  controller can accept a request.
- REQ_OPCODE  in  4  ARM data-processing opcode.
- REQ_S  in  1  update flags.
- REQ_MUL  in  1  multiply request (see Optional Feature).
- REQ_A  in  32  operand A (Rn).
- REQ_B  in  32  operand B (shifter output).
- REQ_SHC  in  1  shifter carry-out.
- ALU_A, ALU_B  out  32  ALU operands.
- ALU_INVA, ALU_INVB, ALU_PASSA, ALU_PASSB, ALU_AND, ALU_ORR, ALU_EOR, ALU_CIN, ALU_CUSE  out  1 each  ALU controls.
- ALU_DOUT  in  32  ALU result.
- ALU_C, ALU_V, ALU_N, ALU_Z  in  1 each  ALU flags.
- RES_VALID  out  1  result available.
- RES_READY  in  1  consumer accepts the result.
- RES_DATA  out  32  result.
- RES_WE  out  1  result targets Rd; 0 for TST/TEQ/CMP/CMN.
- FLAGS  out  4  NZCV register, bit 3 = N.

Behaviour:
- Clock and reset: single clock CLK. nRESET is synchronous, active-low, and sampled on posedge CLK.
- Reset state: IDLE, REQ_READY=1, RES_VALID=0, RES_DATA=0, RES_WE=0, FLAGS=0.
  - All ALU control outputs are 0 and ALU_A/ALU_B are 0.
  - Reset asserted in any state aborts the operation and discards any pending result.
- FSM states: IDLE, EXEC, (MUL), DONE.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID at a posedge: latch opcode, S, A, B, SHC, and the current FLAGS.C. Go to EXEC.
- EXEC (one cycle):
  - Controls are decoded combinationally from the latched opcode. ALU_A and ALU_B are the latched operands.
  - At the posedge ending EXEC: capture RES_DATA=ALU_DOUT and RES_WE; update FLAGS if S=1. Go to DONE.
- DONE:
  - RES_VALID=1; it holds, with stable data, until RES_READY is sampled 1, then return to IDLE.
  - REQ_READY=0 in EXEC/MUL/DONE. No new request is accepted in the same cycle a result is popped.
- Latency: accept at edge N; capture at N+1; RES_VALID=1 from edge N+1. Throughput is at most 1 request per 3 cycles.
- Opcode decode. Unlisted controls are 0. "Cin=x" means CUSE=1, CIN=x.
  - AND 0: AND. EOR 1: EOR. ORR C: ORR. BIC E: AND+INVB.
  - MOV D: PASSB. MVN F: PASSB+INVB.
  - TST 8: as AND. TEQ 9: as EOR.
  - SUB 2: INVB, Cin=1. RSB 3: INVA, Cin=1.
  - ADD 4: CUSE=0. ADC 5: Cin=latched C.
  - SBC 6: INVB, Cin=latched C. RSC 7: INVA, Cin=latched C.
  - CMP A: as SUB. CMN B: as ADD.
- RES_WE is 0 for opcodes 8-B and 1 otherwise.
- Flag update (only when S=1):
  - N and Z come from ALU_N and ALU_Z.
  - Arithmetic ops (2-7, A, B): C=ALU_C, V=ALU_V.
  - Logical/move ops: C=latched SHC, V unchanged.
  - With S=0, FLAGS is unchanged.

Optional Feature:
- Macro: ALU_MUL_EN.
- Defined: REQ_MUL=1 enters MUL instead of EXEC and runs an iterative shift-add multiply reusing the ALU.
  - The accumulator resets to 0; iteration counter i runs 0..31.
  - Each cycle: ALU_A=acc, ALU_B=A<<i, CUSE=0.
    - If B[i]=1, the ALU performs an add; otherwise it uses PASSA.
  - acc<=ALU_DOUT at each posedge.
  - After i=31: RES_DATA=acc (low 32 bits), RES_WE=1. If S=1, update N and Z; C and V are unchanged. Go to DONE.
  - Latency: accept at N; RES_VALID from edge N+32.
- Undefined: REQ_MUL is ignored; every request follows the data-processing path.

Test Plan:
- Reset and idle: hold nRESET=0 for 2 cycles -> FLAGS=0, RES_VALID=0, REQ_READY=1.
- ADD with flags: ADD S=1, A=32'h7FFFFFFF, B=1 -> RES_DATA=32'h80000000, FLAGS=4'b1001, RES_VALID asserted one edge after accept.
- Compare: CMP S=1, A=5, B=5 -> RES_WE=0, FLAGS=4'b0110.
  - Then ADC S=0, A=1, B=1 -> RES_DATA=3, FLAGS unchanged.
- Logical op and backpressure: BIC S=1, A=32'hFF, B=32'h0F, SHC=1 -> RES_DATA=32'hF0, C=1, V kept.
  - Hold RES_READY=0 for 4 cycles -> RES_VALID and RES_DATA stable, REQ_READY=0.
- Reset mid-operation: assert nRESET=0 during DONE -> next cycle RES_VALID=0, state IDLE, FLAGS=0.
- Multiply (ALU_MUL_EN defined): MUL S=1, A=1234, B=5678 -> RES_DATA=7006652 with RES_VALID 32 edges after accept, Z=0, N=0.
  - MUL with B=0 -> RES_DATA=0, Z=1.
